// File: rtl/sig_src_sel_if.sv
// sig_src_sel_if: sample and control bundle between the source selector and
// its neighbours (ADC front end, ROM simulator, DDC/SRIO datapath).
// master = the side that drives the request/sample inputs, slave = selector.
interface sig_src_sel_if #(
  parameter int N_CH  = 3,
  parameter int N_ADC = 4,
  parameter int DW    = 16,
  parameter int MAP_W = 2
);
  logic                    PRI;
  logic                    sim_sel;
  logic [N_CH*MAP_W-1:0]   adc_map;
  logic [N_CH*DW-1:0]      sim_data;
  logic [N_ADC*DW-1:0]     adc_data;
  logic [N_CH*DW-1:0]      ad_out;
  logic                    src_cur;
  logic                    switching;
  logic [15:0]             sw_cnt;
  logic [N_CH*DW-1:0]      peak_out;

  modport master (
    output PRI, sim_sel, adc_map, sim_data, adc_data,
    input  ad_out, src_cur, switching, sw_cnt, peak_out
  );

  modport slave (
    input  PRI, sim_sel, adc_map, sim_data, adc_data,
    output ad_out, src_cur, switching, sw_cnt, peak_out
  );
endinterface

// File: rtl/sig_src_sel.sv
// sig_src_sel: N-channel signal-source selector (simulator or mapped ADC lane).
// Requested source/lane-map changes are held off until the next PRI rising
// edge, then the outputs are forced to zero for BLANK_CYC clocks before the
// new setting is passed through.
// Optional macro SIG_PEAK_EN: per-channel peak |ad_out| of the previous PRI
// on peak_out; without it peak_out is tied to zero.
module sig_src_sel #(
  parameter int N_CH      = 3,
  parameter int N_ADC     = 4,
  parameter int DW        = 16,
  parameter int MAP_W     = 2,
  parameter int BLANK_CYC = 16
) (
  input logic           clk_100M,
  input logic           rst_n,
  sig_src_sel_if.slave  bus
);

  localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  typedef enum logic [1:0] {RUN, WAIT_PRI, BLANK} state_t;

  // Identity lane map: channel k reads lane k mod N_ADC.
  function automatic logic [N_CH*MAP_W-1:0] identity_map();
    logic [N_CH*MAP_W-1:0] m;
    m = '0;
    for (int k = 0; k < N_CH; k++) m[k*MAP_W +: MAP_W] = MAP_W'(k % N_ADC);
    return m;
  endfunction

  localparam logic [N_CH*MAP_W-1:0] MAP_RST = identity_map();

  state_t                state;
  logic                  switching_q;
  logic                  src_cur_q;
  logic [N_CH*MAP_W-1:0] map_cur;
  logic [CNT_W-1:0]      blank_cnt;
  logic [15:0]           sw_cnt_q;
  logic                  pri_d;
  logic [N_CH*DW-1:0]    ad_out_q;
  logic [N_CH*DW-1:0]    sel_data;
  logic                  pri_rise;
  logic                  req_diff;
  logic                  blank_now;

  assign pri_rise = bus.PRI & ~pri_d;
  assign req_diff = (bus.sim_sel != src_cur_q) || (bus.adc_map != map_cur);

  // Zero the output on the switch edge itself and for every BLANK clock
  // except the last, giving exactly BLANK_CYC zero samples.
  assign blank_now = ((state == WAIT_PRI) && req_diff && pri_rise) ||
                     ((state == BLANK) && (blank_cnt != '0));

  // Per-channel source mux using the applied (not requested) setting.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (src_cur_q) begin
        sel_data[k*DW +: DW] = bus.sim_data[k*DW +: DW];
      end else if (int'(map_cur[k*MAP_W +: MAP_W]) < N_ADC) begin
        sel_data[k*DW +: DW] = bus.adc_data[int'(map_cur[k*MAP_W +: MAP_W])*DW +: DW];
      end
    end
  end

  // Switch-control FSM: wait for PRI boundary, latch request, blank, count.
  always_ff @(posedge clk_100M) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= RUN;
      switching_q <= 1'b0;
      src_cur_q   <= 1'b0;
      map_cur     <= MAP_RST;
      blank_cnt   <= '0;
      sw_cnt_q    <= '0;
      pri_d       <= 1'b0;
    end else begin
      pri_d <= bus.PRI;
      case (state)
        RUN: begin
          if (req_diff) begin
            state       <= WAIT_PRI;
            switching_q <= 1'b1;
          end
        end
        WAIT_PRI: begin
          // A request that has reverted wins over a coincident PRI edge:
          // there is nothing left to switch to.
          if (!req_diff) begin
            state       <= RUN;
            switching_q <= 1'b0;
          end else if (pri_rise) begin
            src_cur_q <= bus.sim_sel;
            map_cur   <= bus.adc_map;
            blank_cnt <= CNT_W'(BLANK_CYC - 1);
            state     <= BLANK;
          end
        end
        BLANK: begin
          if (blank_cnt == '0) begin
            state       <= RUN;
            switching_q <= 1'b0;
            sw_cnt_q    <= sw_cnt_q + 16'd1;
          end else begin
            blank_cnt <= blank_cnt - CNT_W'(1);
          end
        end
        default: begin
          state       <= RUN;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

  // Output register: one-clock latency, zero while blanking.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) ad_out_q <= '0;
    else        ad_out_q <= blank_now ? '0 : sel_data;
  end

  assign bus.ad_out    = ad_out_q;
  assign bus.src_cur   = src_cur_q;
  assign bus.switching = switching_q;
  assign bus.sw_cnt    = sw_cnt_q;

`ifdef SIG_PEAK_EN
  logic [N_CH*DW-1:0] peak_trk;
  logic [N_CH*DW-1:0] peak_q;

  // Two's-complement magnitude; the most negative code saturates.
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] s);
    if (s == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
    else if (s[DW-1])                return -s;
    else                             return s;
  endfunction

  // Peak tracker: publish on PRI edge and restart from the current sample.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      peak_trk <= '0;
      peak_q   <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (pri_rise) begin
          peak_q[k*DW +: DW]   <= peak_trk[k*DW +: DW];
          peak_trk[k*DW +: DW] <= mag(ad_out_q[k*DW +: DW]);
        end else if (mag(ad_out_q[k*DW +: DW]) > peak_trk[k*DW +: DW]) begin
          peak_trk[k*DW +: DW] <= mag(ad_out_q[k*DW +: DW]);
        end
      end
    end
  end

  assign bus.peak_out = peak_q;
`else
  assign bus.peak_out = '0;
`endif

endmodule

// File: tb/tb_sig_src_sel.sv
// tb_sig_src_sel: directed table + hand sequences + randomized stimulus
// against a cycle-level behavioural model of sig_src_sel.
module tb_sig_src_sel;
  localparam int N_CH      = 3;
  localparam int N_ADC     = 4;
  localparam int DW        = 16;
  localparam int MAP_W     = 4;
  localparam int BLANK_CYC = 16;
  localparam int AW        = N_CH * DW;
  localparam int LW        = N_ADC * DW;
  localparam int MW        = N_CH * MAP_W;
  localparam logic [MW-1:0] ID_MAP = 12'h210;

  logic clk_100M = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_100M = ~clk_100M;

  sig_src_sel_if #(.N_CH(N_CH), .N_ADC(N_ADC), .DW(DW), .MAP_W(MAP_W)) bus ();

  sig_src_sel #(
    .N_CH(N_CH), .N_ADC(N_ADC), .DW(DW), .MAP_W(MAP_W), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_src = 1'b0;
  int          m_map [N_CH];
  bit          m_wait = 1'b0;
  bit          m_blank = 1'b0;
  int          m_zeros = 0;
  logic [15:0] m_cnt = '0;
  logic [AW-1:0] m_out = '0;
  bit          m_pri_prev = 1'b0;
  int          m_trk [N_CH];
  int          m_peak [N_CH];

  function automatic int mag(input logic [DW-1:0] x);
    int s;
    s = int'($signed(x));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  function automatic logic [AW-1:0] model_sel();
    logic [AW-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (m_src) r[k*DW +: DW] = bus.sim_data[k*DW +: DW];
      else if (m_map[k] < N_ADC) r[k*DW +: DW] = bus.adc_data[m_map[k]*DW +: DW];
    end
    return r;
  endfunction

  task automatic model_step();
    bit rise, diff;
    int mg;
    logic [AW-1:0] nxt;
    if (!rst_n) begin
      m_src = 1'b0; m_wait = 1'b0; m_blank = 1'b0; m_zeros = 0;
      m_cnt = '0; m_out = '0; m_pri_prev = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        m_map[k] = k % N_ADC; m_trk[k] = 0; m_peak[k] = 0;
      end
      return;
    end
    rise = bus.PRI && !m_pri_prev;
    m_pri_prev = bus.PRI;
    diff = (bus.sim_sel != m_src);
    for (int k = 0; k < N_CH; k++)
      if (int'(bus.adc_map[k*MAP_W +: MAP_W]) != m_map[k]) diff = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      mg = mag(m_out[k*DW +: DW]);
      if (rise) begin m_peak[k] = m_trk[k]; m_trk[k] = mg; end
      else if (mg > m_trk[k]) m_trk[k] = mg;
    end
    nxt = model_sel();
    if (m_blank) begin
      if (m_zeros > 0) begin m_zeros--; m_out = '0; end
      else begin m_blank = 1'b0; m_cnt += 16'd1; m_out = nxt; end
    end else if (m_wait && !diff) begin
      m_wait = 1'b0; m_out = nxt;
    end else if (m_wait && rise) begin
      m_src = bus.sim_sel;
      for (int k = 0; k < N_CH; k++) m_map[k] = int'(bus.adc_map[k*MAP_W +: MAP_W]);
      m_out = '0; m_zeros = BLANK_CYC - 1; m_blank = 1'b1; m_wait = 1'b0;
    end else begin
      if (diff) m_wait = 1'b1;
      m_out = nxt;
    end
  endtask

  task automatic compare_model();
    logic [AW-1:0] pk;
    pk = '0;
`ifdef SIG_PEAK_EN
    for (int k = 0; k < N_CH; k++) pk[k*DW +: DW] = DW'(m_peak[k]);
`endif
    check("mdl_ad_out", bus.ad_out, m_out);
    check("mdl_src_cur", bus.src_cur, m_src);
    check("mdl_switching", bus.switching, m_wait || m_blank);
    check("mdl_sw_cnt", bus.sw_cnt, m_cnt);
    check("mdl_peak_out", bus.peak_out, pk);
  endtask

  task automatic cycle();
    @(posedge clk_100M);
    model_step();
    #1;
    compare_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          sim_sel;
    logic [LW-1:0] adc;
    logic [AW-1:0] sim;
    logic [AW-1:0] exp_out;
    logic          exp_sw;
  } vec_t;

  vec_t vecs [6];
  logic [MW-1:0] maps [4];

  initial begin
    vecs[0] = '{1'b0, 64'h4444_3333_2222_1111, 48'h0, 48'h3333_2222_1111, 1'b0};
    vecs[1] = '{1'b0, 64'h0000_8000_7FFF_FFFF, 48'h5555_6666_7777, 48'h8000_7FFF_FFFF, 1'b0};
    vecs[2] = '{1'b0, 64'hABCD_0001_0002_0003, 48'h1234_5678_9ABC, 48'h0001_0002_0003, 1'b0};
    vecs[3] = '{1'b0, 64'h0, 48'h1, 48'h0, 1'b0};
    vecs[4] = '{1'b1, 64'h4444_3333_2222_1111, 48'hC003_B002_A001, 48'h3333_2222_1111, 1'b1};
    vecs[5] = '{1'b0, 64'h1111_2222_3333_4444, 48'hC003_B002_A001, 48'h2222_3333_4444, 1'b0};
    maps[0] = ID_MAP; maps[1] = 12'h903; maps[2] = 12'h123; maps[3] = 12'hF00;

    bus.PRI = 1'b0; bus.sim_sel = 1'b0; bus.adc_map = ID_MAP;
    bus.sim_data = '0; bus.adc_data = '0; rst_n = 1'b0;
    repeat (3) cycle();
    check("rst_ad_out", bus.ad_out, 0);
    check("rst_src_cur", bus.src_cur, 0);
    check("rst_switching", bus.switching, 0);
    check("rst_sw_cnt", bus.sw_cnt, 0);
    check("rst_peak_out", bus.peak_out, 0);
    rst_n = 1'b1;

    // Passthrough and request/revert without a PRI edge.
    for (int i = 0; i < 6; i++) begin
      bus.sim_sel  = vecs[i].sim_sel;
      bus.adc_data = vecs[i].adc;
      bus.sim_data = vecs[i].sim;
      cycle();
      check($sformatf("vec%0d_ad_out", i), bus.ad_out, vecs[i].exp_out);
      check($sformatf("vec%0d_switching", i), bus.switching, vecs[i].exp_sw);
    end
    check("vec_sw_cnt", bus.sw_cnt, 0);

    // Switch to simulator at a PRI boundary.
    bus.adc_data = 64'h4444_3333_2222_1111;
    bus.sim_data = 48'hC003_B002_A001;
    bus.sim_sel  = 1'b1;
    repeat (3) cycle();
    check("wait_switching", bus.switching, 1);
    check("wait_ad_out", bus.ad_out, 48'h3333_2222_1111);
    bus.PRI = 1'b1;
    cycle();
    check("blank_0", bus.ad_out, 0);
    for (int i = 1; i < BLANK_CYC; i++) begin
      cycle();
      check($sformatf("blank_%0d", i), bus.ad_out, 0);
    end
    check("blank_switching", bus.switching, 1);
    cycle();
    check("sim_ad_out", bus.ad_out, 48'hC003_B002_A001);
    check("sim_src_cur", bus.src_cur, 1);
    check("sim_sw_cnt", bus.sw_cnt, 1);
    check("sim_switching", bus.switching, 0);

    // Revert before the boundary: no blanking, no count.
    bus.sim_sel = 1'b0;
    cycle();
    check("rev_switching_on", bus.switching, 1);
    bus.sim_sel = 1'b1;
    cycle();
    check("rev_switching_off", bus.switching, 0);
    check("rev_ad_out", bus.ad_out, 48'hC003_B002_A001);
    repeat (3) cycle();
    check("rev_sw_cnt", bus.sw_cnt, 1);

    // Remap with one out-of-range lane index.
    bus.PRI = 1'b0; bus.sim_sel = 1'b0; bus.adc_map = 12'h903;
    repeat (2) cycle();
    bus.PRI = 1'b1;
    cycle();
    repeat (BLANK_CYC) cycle();
    check("remap_ad_out", bus.ad_out, 48'h0000_1111_4444);
    check("remap_src_cur", bus.src_cur, 0);
    check("remap_sw_cnt", bus.sw_cnt, 2);

    // Reset in the middle of BLANK.
    bus.PRI = 1'b0; bus.adc_map = ID_MAP; bus.sim_sel = 1'b1;
    cycle();
    bus.PRI = 1'b1;
    cycle();
    repeat (4) cycle();
    check("midblank_ad_out", bus.ad_out, 0);
    check("midblank_switching", bus.switching, 1);
    rst_n = 1'b0; bus.sim_sel = 1'b0;
    cycle();
    check("midrst_ad_out", bus.ad_out, 0);
    check("midrst_src_cur", bus.src_cur, 0);
    check("midrst_switching", bus.switching, 0);
    check("midrst_sw_cnt", bus.sw_cnt, 0);
    check("midrst_peak_out", bus.peak_out, 0);
    rst_n = 1'b1; bus.PRI = 1'b0;
    repeat (2) cycle();
    check("postrst_ad_out", bus.ad_out, 48'h3333_2222_1111);
    check("postrst_switching", bus.switching, 0);

    // Peak tracking over one PRI: +100, -32768, -50.
    bus.adc_data = '0;
    repeat (2) cycle();
    bus.PRI = 1'b1;
    cycle();
    bus.adc_data = {4{16'd100}};  cycle();
    bus.adc_data = {4{16'h8000}}; cycle();
    bus.adc_data = {4{16'hFFCE}}; cycle();
    bus.adc_data = '0; bus.PRI = 1'b0; cycle();
    bus.PRI = 1'b1;
    cycle();
`ifdef SIG_PEAK_EN
    check("peak_sat", bus.peak_out, {3{16'h7FFF}});
`else
    check("peak_off", bus.peak_out, 0);
`endif

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.adc_data = LW'({$urandom(), $urandom()});
      bus.sim_data = AW'({$urandom(), $urandom()});
      if ($urandom_range(0, 19) == 0) bus.PRI = ~bus.PRI;
      if ($urandom_range(0, 59) == 0) bus.sim_sel = ~bus.sim_sel;
      if ($urandom_range(0, 79) == 0) bus.adc_map = maps[$urandom_range(0, 3)];
      rst_n = ($urandom_range(0, 999) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
